// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single-port access controller for the 32x4 lab RAM.
// Three requesters share the RAM port through a fixed-priority FSM: bulk clear,
// the user read/write port and the periodic display scanner.
// Build option: define RAM_ACCESS_CTRL_SCAN_EN to include the display scanner
// (tick counter, SCAN_RD states). Without it the disp_* outputs are tied to 0.
module ram_access_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_data,
    output logic              usr_ack,
    output logic [DATA_W-1:0] usr_rdata,
    output logic              usr_rvalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        USR_WR,
        USR_RD1,
        USR_RD2,
        SCAN_RD1,
        SCAN_RD2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_t state;
    logic   clear_pending;

    // A scan period shorter than one scan read cannot be serviced.
    if (TICK_DIV < 4) begin : g_tick_div_too_small
    end

`ifdef RAM_ACCESS_CTRL_SCAN_EN
    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_wrap;
    logic              scan_pending;
    logic [ADDR_W-1:0] scan_ptr;

    assign tick_wrap = (tick_cnt == TICK_LAST);

    // Free-running scan period counter; its wrap requests one display read.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_wrap) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end
`else
    assign disp_addr  = '0;
    assign disp_data  = '0;
    assign disp_valid = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Arbitration FSM with registered RAM controls, handshakes and display regs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            usr_ack       <= 1'b0;
            usr_rdata     <= '0;
            usr_rvalid    <= 1'b0;
            ram_address   <= '0;
            ram_data      <= '0;
            ram_wren      <= 1'b0;
`ifdef RAM_ACCESS_CTRL_SCAN_EN
            scan_pending  <= 1'b0;
            scan_ptr      <= '0;
            disp_addr     <= '0;
            disp_data     <= '0;
            disp_valid    <= 1'b0;
`endif
        end else begin
            usr_ack    <= 1'b0;
            usr_rvalid <= 1'b0;

            // A clear request arriving while a clear runs is dropped.
            if (clr_start && (state != CLEAR)) begin
                clear_pending <= 1'b1;
            end
`ifdef RAM_ACCESS_CTRL_SCAN_EN
            // Ticks merge: one pending flag, no queue.
            if (tick_wrap) begin
                scan_pending <= 1'b1;
            end
`endif

            case (state)
                IDLE: begin
                    ram_wren <= 1'b0;
                    // clr_start is looked at directly so a same-cycle user
                    // request cannot slip ahead of the clear.
                    if (clear_pending || clr_start) begin
                        clear_pending <= 1'b0;
                        ram_address   <= '0;
                        ram_data      <= clr_value;
                        ram_wren      <= 1'b1;
                        state         <= CLEAR;
                    end else if (usr_req) begin
                        ram_address <= usr_addr;
                        usr_ack     <= 1'b1;
                        if (usr_we) begin
                            ram_data <= usr_data;
                            ram_wren <= 1'b1;
                            state    <= USR_WR;
                        end else begin
                            state <= USR_RD1;
                        end
                    end
`ifdef RAM_ACCESS_CTRL_SCAN_EN
                    else if (scan_pending) begin
                        ram_address <= scan_ptr;
                        state       <= SCAN_RD1;
                    end
`endif
                end

                // One write per cycle; after the last word a single idle
                // cycle with ram_wren low closes the fill.
                CLEAR: begin
                    if (!ram_wren) begin
                        state <= IDLE;
                    end else if (ram_address == ADDR_LAST) begin
                        ram_wren <= 1'b0;
                    end else begin
                        ram_address <= ram_address + ADDR_ONE;
                    end
                end

                USR_WR: begin
                    ram_wren <= 1'b0;
                    state    <= IDLE;
                end

                USR_RD1: begin
                    state <= USR_RD2;
                end

                USR_RD2: begin
                    usr_rdata  <= ram_q;
                    usr_rvalid <= 1'b1;
                    state      <= IDLE;
                end

`ifdef RAM_ACCESS_CTRL_SCAN_EN
                SCAN_RD1: begin
                    state <= SCAN_RD2;
                end

                SCAN_RD2: begin
                    disp_data  <= ram_q;
                    disp_addr  <= scan_ptr;
                    disp_valid <= 1'b1;
                    scan_ptr   <= scan_ptr + ADDR_ONE;
                    if (!tick_wrap) begin
                        scan_pending <= 1'b0;
                    end
                    state <= IDLE;
                end
`endif

                default: begin
                    ram_wren <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Single-port access controller for the 32x4 synchronous RAM used in the lab memory datapath. It shares the one RAM port between three requesters: a bulk clear engine, a user read/write port (switch/key driven), and a periodic display scanner that feeds the hex-digit path. A fixed-priority FSM serializes the requesters and drives registered RAM control signals.

## Interface

Parameters
- ADDR_W, 5, RAM address width; depth = 2^ADDR_W
- DATA_W, 4, RAM word width
- TICK_DIV, 50000000, clock cycles between display-scan steps (>= 4)

Ports
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clr_start  in  1  one-cycle pulse: fill entire RAM with clr_value
- clr_value  in  DATA_W  fill word, sampled at clear grant
- usr_req  in  1  user access request, held until usr_ack
- usr_we  in  1  1 = write, 0 = read; valid with usr_req
- usr_addr  in  ADDR_W  user address
- usr_data  in  DATA_W  user write data
- usr_ack  out  1  one-cycle pulse: user request granted
- usr_rdata  out  DATA_W  user read result
- usr_rvalid  out  1  one-cycle pulse: usr_rdata updated
- ram_address  out  ADDR_W  to RAM address (registered)
- ram_data  out  DATA_W  to RAM data (registered)
- ram_wren  out  1  to RAM write enable (registered)
- ram_q  in  DATA_W  RAM read data, valid one cycle after address sampled
- disp_addr  out  ADDR_W  address of currently displayed word
- disp_data  out  DATA_W  word shown on hex digit
- disp_valid  out  1  high once first scan read completes; sticky until reset
- busy  out  1  high in any state other than IDLE

## Operation

- States: IDLE, CLEAR, USR_WR, USR_RD1, USR_RD2, SCAN_RD1, SCAN_RD2.
- Arbitration in IDLE only, fixed priority: clear_pending > usr_req > scan_pending.
- clear_pending: set by clr_start in any state; cleared at clear grant. clr_start during CLEAR is dropped (pending already consumed is not re-set).
- CLEAR: at grant load ram_address=0, ram_data=clr_value, ram_wren=1; increment address each cycle; after address 2^ADDR_W-1 is written, ram_wren=0, return IDLE. Exactly 2^ADDR_W write cycles.
- User write: grant edge loads ram_address/ram_data, ram_wren=1, usr_ack=1 -> USR_WR; next edge RAM writes, ram_wren=0, -> IDLE.
- User read: grant edge loads ram_address, ram_wren=0, usr_ack=1 -> USR_RD1 -> USR_RD2; on leaving USR_RD2 capture ram_q into usr_rdata, pulse usr_rvalid, -> IDLE.
- Scanner: free-running tick counter 0..TICK_DIV-1; wrap sets scan_pending. Scan grant issues read of scan_ptr; two edges later disp_data<=ram_q, disp_addr<=scan_ptr, disp_valid<=1, scan_ptr increments mod 2^ADDR_W (31 -> 0), scan_pending cleared. A tick arriving while scan_pending is already set is merged (no queue).
- ram_wren is 0 in every state except CLEAR and the USR_WR grant cycle.
- Reset (including mid-CLEAR or mid-read): state IDLE, all outputs 0, pending flags 0, tick counter 0, scan_ptr 0. Interrupted clear is not resumed; RAM contents undefined beyond written words.

## Timing

- Edge E0 = grant edge. Write: ram_wren high E0..E1, write lands at E1; usr_ack high E0..E1; next grant possible at E2 (2 cycles/write).
- Read: RAM samples address at E1; usr_rdata/usr_rvalid updated at E2; next grant at E3 (3 cycles/read).
- Clear: 2^ADDR_W + 1 cycles from grant to IDLE (33 for defaults).
- Requester must drop usr_req after sampling usr_ack; a held usr_req is regranted at the next IDLE edge.
- Scan latency from tick wrap to disp update: 3 cycles if IDLE, otherwise deferred until clear and all pending user requests finish.

## Configuration

- RAM_ACCESS_CTRL_SCAN_EN defined: scanner, tick counter, SCAN_RD states present as above.
- Not defined: scanner logic removed; disp_addr, disp_data, disp_valid tied to 0; scan_pending never set; user/clear behaviour and timing unchanged.

## Test plan

- Reset -> all outputs 0, busy=0; after reset release with no requests, ram_wren stays 0.
- clr_start with clr_value=4'hA -> 32 consecutive writes, addresses 0..31, busy high 33 cycles; subsequent user reads of 0, 17, 31 return 4'hA.
- User write addr 5 data 4'h3, then read addr 5 -> usr_ack one cycle each, usr_rvalid 2 cycles after read ack with usr_rdata=4'h3.
- clr_start and usr_req asserted same cycle -> clear served first; usr_ack asserts exactly one cycle after CLEAR exits.
- TICK_DIV=4, RAM preloaded addr n = n[3:0] -> disp_addr steps 0,1,2,...,31,0 with disp_data = addr[3:0]; disp_valid rises after first step.
- reset asserted at clear address 10 -> IDLE next cycle, ram_wren=0, no further writes; new clr_start completes full 32-word fill.
